// File: rtl/frame_pixel_streamer.sv
// rtl/frame_pixel_streamer.sv - raster-order frame reader feeding a backpressured pixel stream
module frame_pixel_streamer #(
    parameter int N      = 720,
    parameter int M      = 1280,
    parameter int ADDR_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              fill_now,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic [7:0]        pix_out,
    output logic              pix_valid,
    output logic              sof,
    output logic              eol,
    output logic              busy,
    output logic              frame_done
);

    localparam int RW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (M > 1) ? $clog2(M) : 1;
    localparam logic [ADDR_W:0]   TOTAL     = (ADDR_W+1)'(N*M);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N*M-1);
    localparam logic [RW-1:0]     LAST_ROW  = RW'(N-1);
    localparam logic [CW-1:0]     LAST_COL  = CW'(M-1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W:0]   rd_cnt;
    logic              rd_pend;
    logic [1:0]        occ;
    logic [7:0]        buf0;
    logic [7:0]        buf1;
    logic [RW-1:0]     row;
    logic [CW-1:0]     col;
    logic              pop;
    logic              push;
    logic              at_eol;
    logic              last_beat;
    logic [2:0]        credit;

    // Credit counts the slot freed by this cycle's pop so reads keep pace at 1/cycle.
    always_comb begin
        pix_valid  = (state == STREAM) && (occ != 2'd0);
        pop        = pix_valid && fill_now;
        push       = rd_pend;
        at_eol     = (col == LAST_COL);
        eol        = pix_valid && at_eol;
        sof        = pix_valid && (row == '0) && (col == '0);
        last_beat  = pop && at_eol && (row == LAST_ROW);
        credit     = 3'(occ) - 3'(pop) + 3'(rd_pend);
        mem_rd     = (state == STREAM) && (credit < 3'd2) && (rd_cnt < TOTAL);
        pix_out    = pix_valid ? buf0 : 8'h00;
        busy       = (state == STREAM);
        frame_done = (state == DONE);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = STREAM;
            STREAM:  if (last_beat) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            rd_cnt   <= '0;
            mem_addr <= '0;
            rd_pend  <= 1'b0;
            occ      <= 2'd0;
            buf0     <= 8'h00;
            buf1     <= 8'h00;
            row      <= '0;
            col      <= '0;
        end else begin
            state   <= state_nxt;
            rd_pend <= mem_rd;

            if (state == IDLE && start) begin
                rd_cnt   <= '0;
                mem_addr <= '0;
                row      <= '0;
                col      <= '0;
            end else if (state == DONE) begin
                mem_addr <= '0;
            end else if (mem_rd) begin
                rd_cnt <= rd_cnt + 1'b1;
                if (mem_addr != LAST_ADDR)
                    mem_addr <= mem_addr + 1'b1;
            end

            // Two-entry skid buffer: buf0 is always the head.
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0)
                        buf0 <= mem_rd_data;
                    else
                        buf1 <= mem_rd_data;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    buf0 <= buf1;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        buf0 <= mem_rd_data;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= mem_rd_data;
                    end
                end
                default: ;
            endcase

            if (pop) begin
                if (at_eol) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

endmodule
